// File: rtl/hero_write_rx.sv
// hero_write_rx: receive end of the hero write bus.
// Registers incoming beats, frames them into transactions, buffers them in a
// small FIFO and presents them on a valid/ready interface. One credit pulse is
// returned to the transmitter for every beat drained downstream.
module hero_write_rx #(
  parameter int DEPTH     = 4,
  parameter int MAX_BEATS = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [45:0]                  hero_wr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [35:0]                  out_wdat,
  output logic [6:0]                   out_sub,
  output logic                         out_last,
  output logic [$clog2(MAX_BEATS)-1:0] out_beat_idx,
  output logic                         credit_return,
  output logic                         txn_done,
  output logic                         err_ovf,
  output logic                         err_proto,
  output logic                         err_len,
  input  logic                         err_clr
);

  localparam int AW   = $clog2(DEPTH);
  localparam int IDXW = $clog2(MAX_BEATS);
  localparam int EW   = 44 + IDXW;

  localparam logic [1:0] CT_IDLE    = 2'd0;
  localparam logic [1:0] CT_DONE    = 2'd2;
  localparam logic [1:0] CT_ILLEGAL = 2'd3;

  typedef enum logic [0:0] {
    WAIT_S   = 1'b0,
    IN_TXN_S = 1'b1
  } state_t;

  logic [45:0]     in_q;
  state_t          state_q, state_d;
  logic [IDXW-1:0] bcnt_q, bcnt_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            credit_q, credit_d;
  logic            txn_done_q, txn_done_d;
  logic            err_ovf_q, err_ovf_d;
  logic            err_proto_q, err_proto_d;
  logic            err_len_q, err_len_d;

  logic [EW-1:0]   wr_entry_d;
  logic [EW-1:0]   head_s;
  logic            wr_en_s;
  logic            pop_s;
  logic            full_s;
  logic            legal_s;
  logic            proto_s;
  logic            wr_last_s;
  logic            len_hit_s;

  // Next-state logic: beat qualification, framing, FIFO pointers and flags.
  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wr_last_s   = 1'b0;
    len_hit_s   = 1'b0;

    pop_s   = (count_q != {(AW+1){1'b0}}) & out_ready;
    full_s  = (count_q == (AW+1)'(DEPTH));
    legal_s = in_q[0] & (in_q[45:44] != CT_IDLE) & (in_q[45:44] != CT_ILLEGAL);
    proto_s = in_q[0] & (in_q[45:44] == CT_ILLEGAL);

    // Framing advances on every legal beat, even one later dropped on overflow.
    if (legal_s) begin
      if (in_q[45:44] == CT_DONE) begin
        wr_last_s = 1'b1;
        state_d   = WAIT_S;
        bcnt_d    = {IDXW{1'b0}};
      end else if (bcnt_q == IDXW'(MAX_BEATS - 1)) begin
        wr_last_s = 1'b1;
        len_hit_s = 1'b1;
        state_d   = WAIT_S;
        bcnt_d    = {IDXW{1'b0}};
      end else begin
        state_d   = IN_TXN_S;
        bcnt_d    = bcnt_q + IDXW'(1);
      end
    end else begin
      state_d = state_q;
    end

    wr_entry_d = {in_q[43:8], in_q[7:1], wr_last_s, bcnt_q};
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    wr_en_s    = legal_s & (~full_s | pop_s);

    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    credit_d    = pop_s;
    txn_done_d  = legal_s & wr_last_s;
    // Set takes priority over a clear arriving in the same cycle.
    err_ovf_d   = (err_ovf_q & ~err_clr) | (legal_s & full_s & ~pop_s);
    err_proto_d = (err_proto_q & ~err_clr) | proto_s;
    err_len_d   = (err_len_q & ~err_clr) | len_hit_s;
  end

  // Control state: input register, framing FSM, FIFO pointers and output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q        <= 46'd0;
      state_q     <= WAIT_S;
      bcnt_q      <= {IDXW{1'b0}};
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {(AW+1){1'b0}};
      credit_q    <= 1'b0;
      txn_done_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_proto_q <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      in_q        <= hero_wr;
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      credit_q    <= credit_d;
      txn_done_q  <= txn_done_d;
      err_ovf_q   <= err_ovf_d;
      err_proto_q <= err_proto_d;
      err_len_q   <= err_len_d;
    end
  end

  // Beat storage; contents are only observed through the occupancy-gated head.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= wr_entry_d;
    end
  end

  assign out_valid     = (count_q != {(AW+1){1'b0}});
  assign head_s        = out_valid ? mem_q[rd_ptr_q] : {EW{1'b0}};
  assign out_wdat      = head_s[43+IDXW:8+IDXW];
  assign out_sub       = head_s[7+IDXW:1+IDXW];
  assign out_last      = head_s[IDXW];
  assign out_beat_idx  = head_s[IDXW-1:0];
  assign credit_return = credit_q;
  assign txn_done      = txn_done_q;
  assign err_ovf       = err_ovf_q;
  assign err_proto     = err_proto_q;
  assign err_len       = err_len_q;

endmodule

// File: tb/tb_hero_write_rx.sv
// Self-checking bench for hero_write_rx: a scoreboard queue of expected beats
// is filled as stimulus is driven and drained as the DUT hands beats out.
module tb_hero_write_rx;

  localparam int DEPTH     = 4;
  localparam int MAX_BEATS = 16;
  localparam logic [1:0] CT_VALID = 2'd1;
  localparam logic [1:0] CT_DONE  = 2'd2;
  localparam logic [1:0] CT_BAD   = 2'd3;

  typedef struct packed {
    logic [35:0] wdat;
    logic [6:0]  sub;
    logic        last;
    logic [3:0]  idx;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [45:0] hero_wr;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] out_wdat;
  logic [6:0]  out_sub;
  logic        out_last;
  logic [3:0]  out_beat_idx;
  logic        credit_return;
  logic        txn_done;
  logic        err_ovf;
  logic        err_proto;
  logic        err_len;
  logic        err_clr;

  int   chk_cnt = 0;
  int   err_cnt = 0;
  int   pops    = 0;
  int   credits = 0;
  int   txns    = 0;
  int   mcnt    = 0;
  exp_t sb_q[$];

  hero_write_rx #(.DEPTH(DEPTH), .MAX_BEATS(MAX_BEATS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hero_wr       (hero_wr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_wdat      (out_wdat),
    .out_sub       (out_sub),
    .out_last      (out_last),
    .out_beat_idx  (out_beat_idx),
    .credit_return (credit_return),
    .txn_done      (txn_done),
    .err_ovf       (err_ovf),
    .err_proto     (err_proto),
    .err_len       (err_len),
    .err_clr       (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle on hero_wr; the reference framing model decides idx/last.
  task automatic send(input logic [1:0] ct, input logic en, input logic [35:0] wd,
                      input logic [6:0] sb, input bit store);
    exp_t e;
    hero_wr = {ct, wd, sb, en};
    if (en && (ct == CT_VALID || ct == CT_DONE)) begin
      e.wdat = wd;
      e.sub  = sb;
      e.idx  = 4'(mcnt);
      if (ct == CT_DONE || mcnt == MAX_BEATS - 1) begin
        e.last = 1'b1;
        mcnt   = 0;
      end else begin
        e.last = 1'b0;
        mcnt   = mcnt + 1;
      end
      if (store) sb_q.push_back(e);
    end
    tick();
    hero_wr = 46'd0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_wdat"}, 64'(out_wdat), 64'd0);
    check_eq({tag, "_last"}, 64'(out_last), 64'd0);
    check_eq({tag, "_idx"}, 64'(out_beat_idx), 64'd0);
    check_eq({tag, "_credit"}, 64'(credit_return), 64'd0);
    check_eq({tag, "_txn"}, 64'(txn_done), 64'd0);
    check_eq({tag, "_errs"}, 64'({err_ovf, err_proto, err_len}), 64'd0);
  endtask

  // Output monitor: compare every accepted beat with the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (credit_return) credits++;
      if (txn_done) txns++;
      if (out_valid && out_ready) begin
        pops++;
        if (sb_q.size() == 0) begin
          check_eq("unexpected_beat", 64'(out_beat_idx), 64'hFFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("beat_wdat", 64'(out_wdat), 64'(e.wdat));
          check_eq("beat_sub", 64'(out_sub), 64'(e.sub));
          check_eq("beat_last", 64'(out_last), 64'(e.last));
          check_eq("beat_idx", 64'(out_beat_idx), 64'(e.idx));
        end
      end
    end
  end

  initial begin
    int p0;
    int c0;
    int t0;
    rst_n     = 1'b0;
    hero_wr   = 46'd0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    repeat (2) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single DONE beat: latency, last/idx, txn_done and credit timing.
    out_ready = 1'b1;
    p0 = pops; c0 = credits; t0 = txns;
    send(CT_DONE, 1'b1, 36'h123456789, 7'h55, 1'b1);
    check_eq("single_valid_n1", 64'(out_valid), 64'd0);
    tick();
    check_eq("single_valid_n2", 64'(out_valid), 64'd1);
    check_eq("single_last", 64'(out_last), 64'd1);
    check_eq("single_idx", 64'(out_beat_idx), 64'd0);
    check_eq("single_txn_done", 64'(txn_done), 64'd1);
    check_eq("single_credit_early", 64'(credit_return), 64'd0);
    tick();
    check_eq("single_credit", 64'(credit_return), 64'd1);
    check_eq("single_txn_pulse", 64'(txn_done), 64'd0);
    tick();
    check_eq("single_credit_pulse", 64'(credit_return), 64'd0);
    check_eq("single_txn_count", 64'(txns - t0), 64'd1);
    check_eq("single_credit_count", 64'(credits - c0), 64'd1);

    // Three-beat transaction with ignored clk_en=0 bubbles between beats.
    p0 = pops; t0 = txns;
    send(CT_VALID, 1'b1, 36'hA_0000_0001, 7'h01, 1'b1);
    send(CT_VALID, 1'b0, 36'hB_BBBB_BBBB, 7'h7F, 1'b1);
    send(CT_VALID, 1'b1, 36'hA_0000_0002, 7'h02, 1'b1);
    send(CT_DONE,  1'b0, 36'hC_CCCC_CCCC, 7'h7E, 1'b1);
    send(CT_DONE,  1'b1, 36'hA_0000_0003, 7'h03, 1'b1);
    repeat (4) tick();
    check_eq("three_pops", 64'(pops - p0), 64'd3);
    check_eq("three_txn", 64'(txns - t0), 64'd1);
    check_eq("three_sb_empty", 64'(sb_q.size()), 64'd0);

    // Backpressure: four beats fit, the fifth overflows and is dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(CT_VALID, 1'b1, 36'(32'h1000 + i), 7'(i), (i < 4));
    end
    check_eq("ovf_not_yet", 64'(err_ovf), 64'd0);
    tick();
    check_eq("ovf_set", 64'(err_ovf), 64'd1);
    check_eq("ovf_head_valid", 64'(out_valid), 64'd1);
    p0 = pops; c0 = credits;
    out_ready = 1'b1;
    repeat (8) tick();
    check_eq("ovf_drain_pops", 64'(pops - p0), 64'd4);
    check_eq("ovf_drain_credits", 64'(credits - c0), 64'd4);
    check_eq("ovf_empty", 64'(out_valid), 64'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("ovf_cleared", 64'(err_ovf), 64'd0);
    send(CT_DONE, 1'b1, 36'h5_5555_5555, 7'h33, 1'b1);
    repeat (3) tick();

    // Full FIFO with a pop in the same cycle as a write.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(CT_VALID, 1'b1, 36'(32'h2000 + i), 7'(8 + i), 1'b1);
    end
    repeat (2) tick();
    p0 = pops; c0 = credits;
    send(CT_VALID, 1'b1, 36'h2004, 7'h0C, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("fullpop_no_ovf", 64'(err_ovf), 64'd0);
    check_eq("fullpop_one_pop", 64'(pops - p0), 64'd1);
    out_ready = 1'b1;
    repeat (8) tick();
    check_eq("fullpop_drain", 64'(pops - p0), 64'd5);
    check_eq("fullpop_credits", 64'(credits - c0), 64'd5);
    send(CT_DONE, 1'b1, 36'h6_6666_6666, 7'h44, 1'b1);
    repeat (3) tick();

    // Illegal cycle type: flagged, dropped, no credit.
    p0 = pops; c0 = credits;
    send(CT_BAD, 1'b1, 36'hD_EAD0_0000, 7'h11, 1'b0);
    check_eq("proto_not_yet", 64'(err_proto), 64'd0);
    tick();
    check_eq("proto_set", 64'(err_proto), 64'd1);
    repeat (3) tick();
    check_eq("proto_no_beat", 64'(pops - p0), 64'd0);
    check_eq("proto_no_credit", 64'(credits - c0), 64'd0);

    // Length limit: the 16th VALID is truncated to last with idx 15.
    for (int i = 0; i < MAX_BEATS; i++) begin
      send(CT_VALID, 1'b1, 36'(32'h3000 + i), 7'(i), 1'b1);
    end
    check_eq("len_not_yet", 64'(err_len), 64'd0);
    send(CT_VALID, 1'b1, 36'h3100, 7'h20, 1'b1);
    check_eq("len_set", 64'(err_len), 64'd1);
    check_eq("len_txn_done", 64'(txn_done), 64'd1);
    check_eq("len_head_idx", 64'(out_beat_idx), 64'd15);
    check_eq("len_head_last", 64'(out_last), 64'd1);
    send(CT_DONE, 1'b1, 36'h3101, 7'h21, 1'b1);
    repeat (4) tick();
    check_eq("len_sb_empty", 64'(sb_q.size()), 64'd0);

    // Reset in the middle of a buffered transaction.
    out_ready = 1'b0;
    send(CT_VALID, 1'b1, 36'h4000, 7'h40, 1'b1);
    send(CT_VALID, 1'b1, 36'h4001, 7'h41, 1'b1);
    repeat (2) tick();
    check_eq("rst_pre_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    sb_q.delete();
    mcnt = 0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    p0 = pops;
    send(CT_DONE, 1'b1, 36'h4002, 7'h42, 1'b1);
    repeat (4) tick();
    check_eq("postrst_pops", 64'(pops - p0), 64'd1);
    check_eq("final_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/hero_write_rx.md
# hero_write_rx

Receive end of the hero write bus. Accepts a stream of `hero_write_t` beats framed by `CYCLE_TYPE_E` (zero or more VALID beats closed by one DONE beat) and buffers them in a small FIFO. It presents each beat downstream on a valid/ready interface with a last flag and a beat index. Flow control back to the transmitter is credit based: one credit pulse is returned per beat drained downstream.

## Interface
- `DEPTH`, 4: beat FIFO depth; equals the transmitter's initial credit count; power of two, at least 2.
- `MAX_BEATS`, 16: maximum beats per transaction, DONE beat included; at least 2.
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `hero_wr` in 46 (`hero_write_t`): fields are `cycle_type[45:44]`, `wdat[43:8]`, `another_type_reference[7:1]`, `clk_en[0]`.
- `out_valid` out 1: a beat is available.
- `out_ready` in 1: downstream accepts the beat.
- `out_wdat` out 36: beat data.
- `out_sub` out 7 (`sub_def_t`): beat sideband.
- `out_last` out 1: final beat of its transaction.
- `out_beat_idx` out clog2(MAX_BEATS): position of the beat within its transaction, 0-based.
- `credit_return` out 1: one-cycle pulse, one credit.
- `txn_done` out 1: one-cycle pulse when a transaction's last beat is accepted at the input.
- `err_ovf`, `err_proto`, `err_len` out 1 each: sticky error flags.
- `err_clr` in 1: synchronous clear of all three error flags.

## Operation
- **Beat qualification.** A cycle is a beat when `clk_en`=1 and `cycle_type`≠IDLE. When `clk_en`=0 the cycle is ignored, whatever the value of `cycle_type`.
- **Input register.** `hero_wr` is registered once. All decisions below are made on the registered copy.
- **Framing FSM.** Two states, `WAIT_S` (reset) and `IN_TXN_S`:
  - `WAIT_S` + VALID → `IN_TXN_S`.
  - `WAIT_S` + DONE → `WAIT_S` (single-beat transaction).
  - `IN_TXN_S` + VALID → `IN_TXN_S`.
  - `IN_TXN_S` + DONE → `WAIT_S`.
- **Beat counter.**
  - Cleared on entry to `WAIT_S`.
  - Incremented on every VALID beat.
  - The stored `beat_idx` equals the counter value before the increment.
  - The last flag is set for DONE.
- **Length limit.** A VALID beat arriving with counter = MAX_BEATS-1:
  - sets `err_len`;
  - is stored with last=1;
  - returns the FSM to `WAIT_S` and clears the counter.
  - Any following beats start a new transaction.
- **Illegal cycle type.** `cycle_type`=2'd3 with `clk_en`=1:
  - sets `err_proto`;
  - the beat is dropped;
  - FSM and counter are unchanged;
  - no credit is returned.
- **FIFO.** DEPTH entries, each holding {wdat, sub, last, beat_idx}.
  - Write occurs when a legal beat is in the input register and the FIFO is not full.
  - Full with a simultaneous pop counts as not full: the write succeeds.
- **Overflow.** A legal beat arriving at a full FIFO with no pop:
  - sets `err_ovf`;
  - the beat is dropped;
  - FSM, counter and `txn_done` still advance, so framing stays aligned;
  - no credit is returned for the dropped beat.
- **Output.** `out_*` are driven combinationally from the FIFO head. A pop occurs when `out_valid & out_ready`.
- **Credits.** `credit_return` is a registered pulse the cycle after each pop. At most one credit is returned per cycle.
- **Error flags.**
  - Flags are sticky until `err_clr`.
  - `err_clr` is ignored for an error detected in the same cycle; set wins.
- **Reset.** All outputs are 0 on reset, the FIFO is empty, the FSM is in `WAIT_S` and the counter is 0. Reset mid-transaction discards buffered beats and any partial framing. Credits for discarded beats are not returned; the transmitter resets to DEPTH credits along with this block.

## Timing
- A beat on `hero_wr` in cycle N:
  - is registered at the edge ending N;
  - is written to the FIFO at the edge ending N+1;
  - drives `out_valid`=1 in N+2 when the FIFO was empty.
- `txn_done` and error flags assert in N+2, the same cycle as the write result.
- A pop in cycle M asserts `credit_return` in M+1.
- Sustained throughput is one beat per cycle with `out_ready` held at 1.
- Minimum round trip with a continuously ready sink is 4 cycles (beat input → credit back). DEPTH=4 therefore sustains full rate only with a zero-latency transmitter; this is acceptable.
- `out_wdat`, `out_sub`, `out_last` and `out_beat_idx` stay stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- **Single beat.** Drive DONE with wdat=36'h123456789, `out_ready`=1.
  - `out_valid` rises 2 cycles later with `out_last`=1 and `out_beat_idx`=0.
  - `txn_done` pulses once; `credit_return` pulses once, 1 cycle after the pop.
- **Three-beat transaction.** Drive VALID, VALID, DONE back-to-back, with `clk_en`=0 bubbles between them.
  - Output indices are 0, 1, 2; last appears only on idx 2.
  - The bubbles produce no beats.
- **Backpressure and overflow.** Hold `out_ready`=0 and drive 5 VALID beats with DEPTH=4.
  - Four beats are buffered and the 5th sets `err_ovf`.
  - Releasing ready drains exactly 4 beats and returns 4 credits.
  - `err_clr` then clears `err_ovf`.
- **Full with pop.** With the FIFO full, pop and receive a beat in the same cycle.
  - The write succeeds, the count stays 4 and there is no `err_ovf`.
- **Protocol and length errors.**
  - `cycle_type`=3 sets `err_proto` and the beat does not appear at the output.
  - 16 consecutive VALID beats (MAX_BEATS=16) set `err_len` on the 16th, which has idx 15 and last=1. The next VALID has idx 0.
- **Reset mid-transaction.** Drop `rst_n` after 2 VALID beats with 2 beats buffered.
  - All outputs are 0 and the FIFO is empty.
  - After release, a DONE beat is delivered with idx 0.
